stopwatch_sequencer: RTL and testbench

- Mode and run-control sequencer for the four-digit stopwatch/timer display path.
- Sits between the start-signal source and the seven-segment decode/time-mux chain; consumes the divided count tick, switch settings and start control.
- Owns the 4-digit BCD count register and produces four BCD digits for the hex-to-7-segment decoders, plus run/done status.
- Replaces ad-hoc digit feedback loops with a single registered FSM.

---
 rtl/stopwatch_sequencer.sv | 146 ++++++++++++++
 tb/tb_stopwatch_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_sequencer.sv
// Run-control sequencer for the four-digit stopwatch/timer: owns the BCD count
// register, the mode latch and the IDLE/RUN/PAUSE/DONE state machine.
//
// state   | meaning
// IDLE    | digits track the live mode's initial value; waiting for a start edge
// RUN     | counting on tick in the latched direction
// PAUSE   | digits frozen; start edge resumes RUN
// DONE    | terminal value reached (SATURATE only); start edge returns to IDLE
module stopwatch_sequencer #(
   parameter int SATURATE = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       start,
   input  logic [9:0] sw,
   output logic [3:0] out0,
   output logic [3:0] out1,
   output logic [3:0] out2,
   output logic [3:0] out3,
   output logic       running,
   output logic       done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]  state, state_next;
   logic [1:0]  mode, mode_next;
   logic [15:0] count, count_next, count_step;
   logic [15:0] init_val, term_val, preset;
   logic [3:0]  tens_c, units_c, step_digit;
   logic        step_carry;
   logic        start_q, armed, start_edge;

   // armed masks the first clock after reset so a start level held through
   // reset release is not mistaken for a rising edge.
   assign start_edge = start & ~start_q & armed;

   assign tens_c  = (sw[7:4] > 4'd9) ? 4'd9 : sw[7:4];
   assign units_c = (sw[3:0] > 4'd9) ? 4'd9 : sw[3:0];
   assign preset  = {tens_c, units_c, 8'h00};

   always_comb begin
      init_val = 16'h0000;
      case (sw[9:8])
         2'b00:   init_val = 16'h0000;
         2'b01:   init_val = preset;
         2'b10:   init_val = 16'h9999;
         default: init_val = preset;
      endcase
   end

   assign term_val = mode[1] ? 16'h0000 : 16'h9999;

   // BCD step with ripple carry (up) or borrow (down) across the four digits.
   always_comb begin
      count_step = count;
      step_carry = 1'b1;
      step_digit = 4'd0;
      for (int i = 0; i < 4; i++) begin
         step_digit = count[4*i +: 4];
         if (step_carry) begin
            if (!mode[1]) begin
               if (step_digit >= 4'd9) step_digit = 4'd0;
               else begin
                  step_digit = step_digit + 4'd1;
                  step_carry = 1'b0;
               end
            end else begin
               if (step_digit == 4'd0) step_digit = 4'd9;
               else begin
                  step_digit = step_digit - 4'd1;
                  step_carry = 1'b0;
               end
            end
         end
         count_step[4*i +: 4] = step_digit;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         mode    <= 2'b00;
         count   <= 16'h0000;
         start_q <= 1'b0;
         armed   <= 1'b0;
      end else begin
         state   <= state_next;
         mode    <= mode_next;
         count   <= count_next;
         start_q <= start;
         armed   <= 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      mode_next  = mode;
      count_next = count;
      case (state)
         S_IDLE: begin
            count_next = init_val;
            if (start_edge) begin
               mode_next  = sw[9:8];
               state_next = S_RUN;
            end
         end
         S_RUN: begin
            if (start_edge) begin
               state_next = S_PAUSE;
            end else if (tick) begin
               if (SATURATE != 0 && count == term_val) begin
                  state_next = S_DONE;
               end else begin
                  count_next = count_step;
                  if (SATURATE != 0 && count_step == term_val) state_next = S_DONE;
               end
            end
         end
         S_PAUSE: begin
            if (start_edge) state_next = S_RUN;
         end
         S_DONE: begin
            if (start_edge) state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_comb begin
      running = (state == S_RUN);
      done    = (state == S_DONE);
   end

   assign out0 = count[3:0];
   assign out1 = count[7:4];
   assign out2 = count[11:8];
   assign out3 = count[15:12];

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// Scoreboard bench for stopwatch_sequencer: a saturating instance and a
// wrapping instance share stimulus; expectations are queued and checked by a monitor.
module tb_stopwatch_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rst_w = 1'b1;
   logic       tick = 1'b0;
   logic       start = 1'b0;
   logic [9:0] sw = 10'd0;

   logic [3:0] s0, s1, s2, s3, w0, w1, w2, w3;
   logic       s_run, s_done, w_run, w_done;

   typedef struct {
      string       name;
      bit          wrap;
      logic [15:0] digits;
      logic        run;
      logic        dn;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   stopwatch_sequencer #(.SATURATE(1)) u_sat (
      .clk(clk), .reset(rst), .tick(tick), .start(start), .sw(sw),
      .out0(s0), .out1(s1), .out2(s2), .out3(s3),
      .running(s_run), .done(s_done)
   );

   stopwatch_sequencer #(.SATURATE(0)) u_wrap (
      .clk(clk), .reset(rst_w), .tick(tick), .start(start), .sw(sw),
      .out0(w0), .out1(w1), .out2(w2), .out3(w3),
      .running(w_run), .done(w_done)
   );

   // Monitor: pops one expectation per negative edge and compares.
   initial begin
      exp_t        e;
      logic [17:0] act, req;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            e   = q.pop_front();
            act = e.wrap ? {w3, w2, w1, w0, w_run, w_done}
                         : {s3, s2, s1, s0, s_run, s_done};
            req = {e.digits, e.run, e.dn};
            n_checks++;
            if (act !== req) begin
               n_fail++;
               $display("FAIL %s: got digits=%h run=%b done=%b, expected digits=%h run=%b done=%b",
                        e.name, act[17:2], act[1], act[0], req[17:2], req[1], req[0]);
            end
         end
      end
   end

   task automatic expect_state(input string name, input bit wrap, input logic [15:0] d,
                               input logic r, input logic dn);
      exp_t e;
      int   k;
      e.name = name; e.wrap = wrap; e.digits = d; e.run = r; e.dn = dn;
      q.push_back(e);
      k = 0;
      while (q.size() != 0 && k < 4) begin
         @(negedge clk);
         k++;
      end
      #1;
      if (q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: monitor did not consume expectation within 4 cycles", name);
         q.delete();
      end
   endtask

   task automatic do_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1 tick = 1'b1;
         @(posedge clk); #1 tick = 1'b0;
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic reset_sat();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
   endtask

   initial begin
      // Reset with start held high: no phantom edge on release.
      start = 1'b1;
      sw    = 10'b00_0000_0000;
      idle_cycles(2);
      rst = 1'b0;
      idle_cycles(3);
      expect_state("reset_start_held", 0, 16'h0000, 1'b0, 1'b0);
      start = 1'b0;
      idle_cycles(1);
      expect_state("idle_after_start_fall", 0, 16'h0000, 1'b0, 1'b0);

      // Mode 00 count up, pause, resume.
      pulse_start();
      expect_state("mode00_run_entry", 0, 16'h0000, 1'b1, 1'b0);
      do_ticks(12);
      expect_state("mode00_12_ticks", 0, 16'h0012, 1'b1, 1'b0);
      pulse_start();
      do_ticks(5);
      expect_state("mode00_paused", 0, 16'h0012, 1'b0, 1'b0);
      pulse_start();
      do_ticks(1);
      expect_state("mode00_resumed", 0, 16'h0013, 1'b1, 1'b0);

      // Mode 11 preset 01 counts down to 0000 and saturates.
      reset_sat();
      sw = 10'b11_0000_0001;
      idle_cycles(2);
      expect_state("mode11_idle_preset", 0, 16'h0100, 1'b0, 1'b0);
      pulse_start();
      do_ticks(99);
      expect_state("mode11_99_ticks", 0, 16'h0001, 1'b1, 1'b0);
      do_ticks(1);
      expect_state("mode11_terminal", 0, 16'h0000, 1'b0, 1'b1);
      do_ticks(3);
      expect_state("mode11_done_hold", 0, 16'h0000, 1'b0, 1'b1);
      pulse_start();
      expect_state("mode11_back_idle", 0, 16'h0000, 1'b0, 1'b0);
      idle_cycles(1);
      expect_state("mode11_idle_reload", 0, 16'h0100, 1'b0, 1'b0);

      // Mode 01 with clamped preset, saturating vs wrapping instance.
      reset_sat();
      sw = 10'b01_1010_1001;
      rst_w = 1'b0;
      idle_cycles(2);
      expect_state("mode01_clamp_sat", 0, 16'h9900, 1'b0, 1'b0);
      expect_state("mode01_clamp_wrap", 1, 16'h9900, 1'b0, 1'b0);
      pulse_start();
      do_ticks(99);
      expect_state("mode01_sat_done", 0, 16'h9999, 1'b0, 1'b1);
      expect_state("mode01_wrap_9999", 1, 16'h9999, 1'b1, 1'b0);
      do_ticks(1);
      expect_state("mode01_sat_hold", 0, 16'h9999, 1'b0, 1'b1);
      expect_state("mode01_wrap_0000", 1, 16'h0000, 1'b1, 1'b0);
      @(posedge clk); #1 rst_w = 1'b1;

      // Tick and start edge on the same clock: pause wins, no count.
      reset_sat();
      sw = 10'b00_0000_0000;
      idle_cycles(1);
      pulse_start();
      do_ticks(3);
      expect_state("same_cycle_pre", 0, 16'h0003, 1'b1, 1'b0);
      @(posedge clk); #1 begin tick = 1'b1; start = 1'b1; end
      @(posedge clk); #1 begin tick = 1'b0; start = 1'b0; end
      expect_state("same_cycle_pause", 0, 16'h0003, 1'b0, 1'b0);
      sw[9:8] = 2'b10;
      idle_cycles(2);
      pulse_start();
      do_ticks(2);
      expect_state("mode_locked_resume", 0, 16'h0005, 1'b1, 1'b0);

      // Asynchronous reset between clock edges.
      @(posedge clk); #2 rst = 1'b1;
      expect_state("async_reset", 0, 16'h0000, 1'b0, 1'b0);
      @(posedge clk); #1 rst = 1'b0;
      idle_cycles(2);
      expect_state("idle_live_mode10", 0, 16'h9999, 1'b0, 1'b0);
      sw = 10'b01_0011_0111;
      idle_cycles(1);
      expect_state("idle_live_preset", 0, 16'h3700, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
